// File: rtl/k_alu_result_accum_if.sv
// Stream bundle for the K_ALU result accumulator: the ALU sample stream
// coming in and the completed-frame stream going out.
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised, the sender holds
// valid and its data stable until that transfer. Ready may change freely,
// and a sender never waits for ready before raising valid.
interface k_alu_result_accum_if #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 40
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              out_ovf;

   // Upstream producer and downstream consumer seen together from outside.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   // The accumulator's own view.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/k_alu_result_accum.sv
// K_ALU result accumulator: sums FRAME_LEN accepted ALU results into an
// ACC_W-bit accumulator and holds each frame sum, with a per-frame overflow
// flag, until the readout logic takes it.
// State ACCUM takes samples. State HOLD presents a finished frame.
// out_valid and in_ready decode straight from the state register, so a
// frame handshake and a new sample never share a cycle.
module k_alu_result_accum #(
   parameter int DATA_W    = 32,
   parameter int ACC_W     = 40,
   parameter int FRAME_LEN = 4,
   parameter int SIGNED    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   k_alu_result_accum_if.slave  bus,
   output logic                 busy,
   output logic                 dbg_state
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      S_ACCUM = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] out_data_q;
   logic [ACC_W-1:0] ext_data;
   logic [ACC_W-1:0] sum;
   logic [ACC_W:0]   sum_full;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_sticky_q;
   logic             out_ovf_q;
   logic             accept;
   logic             last;
   logic             add_ovf;

   // Widen the sample to accumulator width (sign- or zero-extend).
   if (ACC_W > DATA_W) begin : g_ext
      if (SIGNED != 0) begin : g_sext
         assign ext_data = {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
      end else begin : g_zext
         assign ext_data = {{(ACC_W-DATA_W){1'b0}}, bus.in_data};
      end
   end else begin : g_noext
      assign ext_data = bus.in_data;
   end

   assign accept = bus.in_valid & bus.in_ready;
   assign last   = (cnt_q == LAST_CNT);

   // Add one bit wide and wrap to ACC_W; flag signed or unsigned overflow.
   always_comb begin
      sum_full = {1'b0, acc_q} + {1'b0, ext_data};
      sum      = sum_full[ACC_W-1:0];
      add_ovf  = 1'b0;
      if (SIGNED != 0) begin
         add_ovf = (acc_q[ACC_W-1] == ext_data[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
      end else begin
         add_ovf = sum_full[ACC_W];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: clear wins, the last sample enters HOLD, a frame handshake leaves it.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_ACCUM;
      end else begin
         case (state_q)
            S_ACCUM: if (accept && last) state_d = S_HOLD;
            S_HOLD:  if (bus.out_ready)  state_d = S_ACCUM;
            default: state_d = S_ACCUM;
         endcase
      end
   end

   // Accumulate samples and capture the frame sum on the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_sticky_q <= 1'b0;
         out_data_q   <= '0;
         out_ovf_q    <= 1'b0;
      end else if (clear) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_sticky_q <= 1'b0;
         out_ovf_q    <= 1'b0;
      end else if (accept) begin
         if (last) begin
            out_data_q   <= sum;
            out_ovf_q    <= ovf_sticky_q | add_ovf;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
         end else begin
            acc_q        <= sum;
            cnt_q        <= cnt_q + CNT_W'(1);
            ovf_sticky_q <= ovf_sticky_q | add_ovf;
         end
      end
   end

   assign bus.in_ready  = (state_q == S_ACCUM);
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;
   assign busy          = (cnt_q != '0) || (state_q == S_HOLD);
   assign dbg_state     = (state_q == S_HOLD);
endmodule

// File: tb/tb_k_alu_result_accum.sv
// Bench for k_alu_result_accum. Three instances share one stimulus stream:
// signed 40-bit, unsigned 40-bit and signed 32-bit accumulators. Their
// handshake timing does not depend on the data, so all three stay in step.
module tb_k_alu_result_accum;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic busy_s40, busy_u40, busy_s32;
   logic st_s40, st_u40, st_s32;

   int checks = 0;
   int errors = 0;

   k_alu_result_accum_if #(.DATA_W(32), .ACC_W(40)) if_s40 ();
   k_alu_result_accum_if #(.DATA_W(32), .ACC_W(40)) if_u40 ();
   k_alu_result_accum_if #(.DATA_W(32), .ACC_W(32)) if_s32 ();

   assign if_s40.in_valid  = in_valid;
   assign if_s40.in_data   = in_data;
   assign if_s40.out_ready = out_ready;
   assign if_u40.in_valid  = in_valid;
   assign if_u40.in_data   = in_data;
   assign if_u40.out_ready = out_ready;
   assign if_s32.in_valid  = in_valid;
   assign if_s32.in_data   = in_data;
   assign if_s32.out_ready = out_ready;

   k_alu_result_accum #(.DATA_W(32), .ACC_W(40), .FRAME_LEN(4), .SIGNED(1)) u_s40 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_s40.slave),
      .busy(busy_s40), .dbg_state(st_s40)
   );
   k_alu_result_accum #(.DATA_W(32), .ACC_W(40), .FRAME_LEN(4), .SIGNED(0)) u_u40 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_u40.slave),
      .busy(busy_u40), .dbg_state(st_u40)
   );
   k_alu_result_accum #(.DATA_W(32), .ACC_W(32), .FRAME_LEN(4), .SIGNED(1)) u_s32 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_s32.slave),
      .busy(busy_s32), .dbg_state(st_s32)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic frame4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
      send(a);
      send(b);
      send(c);
      send(d);
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      step();
      step();

      // Reset state.
      chk("rst_out_valid", 64'(if_s40.out_valid), 64'd0);
      chk("rst_in_ready",  64'(if_s40.in_ready),  64'd1);
      chk("rst_busy",      64'(busy_s40),         64'd0);
      chk("rst_out_data",  64'(if_s40.out_data),  64'd0);
      chk("rst_out_ovf",   64'(if_s40.out_ovf),   64'd0);
      rst_n = 1'b1;
      step();

      // 1: basic back-to-back frame, consumer always ready.
      out_ready = 1'b1;
      send(32'd10);
      send(32'd20);
      send(32'd15);
      chk("basic_not_yet_valid", 64'(if_s40.out_valid), 64'd0);
      chk("basic_busy_partial",  64'(busy_s40),         64'd1);
      send(32'd30);
      chk("basic_out_valid", 64'(if_s40.out_valid), 64'd1);
      chk("basic_in_ready",  64'(if_s40.in_ready),  64'd0);
      chk("basic_out_data",  64'(if_s40.out_data),  64'd75);
      chk("basic_out_ovf",   64'(if_s40.out_ovf),   64'd0);
      chk("basic_dbg_hold",  64'(st_s40),           64'd1);
      step();
      chk("basic_after_hs_valid", 64'(if_s40.out_valid), 64'd0);
      chk("basic_after_hs_ready", 64'(if_s40.in_ready),  64'd1);

      // 2: backpressure; pulses while held must be ignored.
      out_ready = 1'b0;
      frame4(32'd10, 32'd20, 32'd15, 32'd30);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 32'd99;
         step();
         chk("bp_out_valid", 64'(if_s40.out_valid), 64'd1);
         chk("bp_out_data",  64'(if_s40.out_data),  64'd75);
         chk("bp_in_ready",  64'(if_s40.in_ready),  64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_release_valid", 64'(if_s40.out_valid), 64'd0);
      chk("bp_release_ready", 64'(if_s40.in_ready),  64'd1);
      chk("bp_release_busy",  64'(busy_s40),         64'd0);

      // 3: signed and unsigned extension.
      frame4(-32'sd5, 32'd3, -32'sd1, 32'd0);
      chk("sgn_small_s40", 64'(if_s40.out_data), 64'h00FF_FFFF_FFFD);
      chk("sgn_small_u40", 64'(if_u40.out_data), 64'h0001_FFFF_FFFD);
      step();
      frame4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      chk("sgn_min_s40",     64'(if_s40.out_data), 64'h00FE_0000_0000);
      chk("sgn_min_s40_ovf", 64'(if_s40.out_ovf),  64'd0);
      chk("sgn_min_u40",     64'(if_u40.out_data), 64'h0002_0000_0000);
      chk("sgn_min_s32",     64'(if_s32.out_data), 64'h0);
      chk("sgn_min_s32_ovf", 64'(if_s32.out_ovf),  64'd1);
      step();
      frame4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("uns_max_u40",     64'(if_u40.out_data), 64'h0003_FFFF_FFFC);
      chk("uns_max_u40_ovf", 64'(if_u40.out_ovf),  64'd0);
      chk("uns_max_s40",     64'(if_s40.out_data), 64'h00FF_FFFF_FFFC);
      step();

      // 4: overflow at 32 bits, sticky flag cleared for the next frame.
      frame4(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
      chk("ovf_s32_data", 64'(if_s32.out_data), 64'h8000_0000);
      chk("ovf_s32_flag", 64'(if_s32.out_ovf),  64'd1);
      chk("ovf_s40_data", 64'(if_s40.out_data), 64'h8000_0000);
      chk("ovf_s40_flag", 64'(if_s40.out_ovf),  64'd0);
      step();
      frame4(32'd1, 32'd1, 32'd1, 32'd1);
      chk("ovf_next_data", 64'(if_s32.out_data), 64'd4);
      chk("ovf_next_flag", 64'(if_s32.out_ovf),  64'd0);
      step();

      // 5: gapped input, then clear mid-frame with a sample offered.
      send(32'd1);
      step();
      send(32'd2);
      step();
      send(32'd3);
      step();
      chk("gap_not_yet_valid", 64'(if_s40.out_valid), 64'd0);
      send(32'd4);
      chk("gap_out_valid", 64'(if_s40.out_valid), 64'd1);
      chk("gap_out_data",  64'(if_s40.out_data),  64'd10);
      step();
      send(32'd7);
      send(32'd8);
      chk("clr_busy_before", 64'(busy_s40), 64'd1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'd100;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("clr_busy_after", 64'(busy_s40),         64'd0);
      chk("clr_out_valid",  64'(if_s40.out_valid), 64'd0);
      frame4(32'd5, 32'd5, 32'd5, 32'd5);
      chk("clr_next_data", 64'(if_s40.out_data), 64'd20);
      step();

      // Clear while a frame with overflow is held drops it.
      out_ready = 1'b0;
      frame4(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
      chk("clr_hold_ovf_before", 64'(if_s32.out_ovf), 64'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_hold_valid", 64'(if_s32.out_valid), 64'd0);
      chk("clr_hold_ovf",   64'(if_s32.out_ovf),   64'd0);
      chk("clr_hold_ready", 64'(if_s32.in_ready),  64'd1);
      chk("clr_hold_busy",  64'(busy_s32),         64'd0);

      // 6: asynchronous reset while holding a frame.
      frame4(32'd1, 32'd2, 32'd3, 32'd4);
      chk("rst_hold_valid_before", 64'(if_s40.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(if_s40.out_valid), 64'd0);
      chk("arst_in_ready",  64'(if_s40.in_ready),  64'd1);
      chk("arst_busy",      64'(busy_s40),         64'd0);
      chk("arst_out_data",  64'(if_s40.out_data),  64'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      frame4(32'd1, 32'd2, 32'd3, 32'd4);
      chk("arst_next_data",  64'(if_s40.out_data),  64'd10);
      chk("arst_next_valid", 64'(if_s40.out_valid), 64'd1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
